// File: rtl/hs_npu_pkg.sv
// hs_npu_pkg: shared types and constants for the NPU memory responder slice.
//   BYTES_PER_WORD     : bytes in one 32-bit word
//   WORDS_PER_LINE_DEF : default number of words in one memory line
//   uword_t            : 32-bit machine word
//   mem_line_t         : one line at the default line width
//   mem_resp_state_e   : responder FSM states
//   lfsr16_next        : one step of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
// Optional build macro used by the responder: HS_NPU_MEM_RESPONDER_JITTER_EN.
package hs_npu_pkg;

   localparam int BYTES_PER_WORD     = 4;
   localparam int WORDS_PER_LINE_DEF = 2;

   typedef logic [31:0] uword_t;
   typedef uword_t [WORDS_PER_LINE_DEF-1:0] mem_line_t;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      READ_WAIT  = 2'd1,
      WRITE_WAIT = 2'd2,
      RESP       = 2'd3
   } mem_resp_state_e;

   // Shift left, feeding back bits 16,14,13,11 (1-based) into bit 0.
   function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
      logic fb;
      fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
      return {cur[14:0], fb};
   endfunction

endpackage

// File: rtl/hs_npu_mem_responder_if.sv
// hs_npu_mem_responder_if: NPU-side line request/response bundle.
//   read_req    : line read request          (master -> slave)
//   write_req   : line write request         (master -> slave)
//   req_address : byte address of the line   (master -> slave)
//   write_data  : line to write              (master -> slave)
//   read_data   : line read                  (slave -> master)
//   mem_valid   : transaction complete pulse (slave -> master)
interface hs_npu_mem_responder_if #(
   parameter int WORDS_PER_LINE = 2
);

   logic                             read_req;
   logic                             write_req;
   logic [31:0]                      req_address;
   logic [WORDS_PER_LINE-1:0][31:0]  write_data;
   logic [WORDS_PER_LINE-1:0][31:0]  read_data;
   logic                             mem_valid;

   modport master (
      output read_req, write_req, req_address, write_data,
      input  read_data, mem_valid
   );

   modport slave (
      input  read_req, write_req, req_address, write_data,
      output read_data, mem_valid
   );

endinterface

// File: rtl/hs_npu_mem_line_array.sv
// hs_npu_mem_line_array: single-clock line array with a line-wide NPU port and
// a word-granular host port. Reads are combinational; the caller registers them.
//   clk          : clock
//   line_we_i    : commit line_wdata_i to line line_idx_i at this edge
//   line_idx_i   : NPU line index
//   line_wdata_i : NPU line write data
//   line_rdata_o : contents of line line_idx_i
//   host_we_i    : commit host_wdata_i to word host_word_i of line host_idx_i
//   host_idx_i   : host line index
//   host_word_i  : host word select within the line
//   host_wdata_i : host write word
//   host_rdata_o : current contents of the selected host word
module hs_npu_mem_line_array #(
   parameter int WORDS_PER_LINE = 2,
   parameter int DEPTH_LINES    = 256,
   parameter int IDX_BITS       = $clog2(DEPTH_LINES),
   parameter int WSEL_W         = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
   input  logic                            clk,
   input  logic                            line_we_i,
   input  logic [IDX_BITS-1:0]             line_idx_i,
   input  logic [WORDS_PER_LINE-1:0][31:0] line_wdata_i,
   output logic [WORDS_PER_LINE-1:0][31:0] line_rdata_o,
   input  logic                            host_we_i,
   input  logic [IDX_BITS-1:0]             host_idx_i,
   input  logic [WSEL_W-1:0]               host_word_i,
   input  logic [31:0]                     host_wdata_i,
   output logic [31:0]                     host_rdata_o
);

   logic [WORDS_PER_LINE-1:0][31:0] mem_q [DEPTH_LINES];

   // Array storage; the two write ports are never active together (host is
   // only accepted when no NPU request is present).
   always_ff @(posedge clk) begin
      if (line_we_i) begin
         mem_q[line_idx_i] <= line_wdata_i;
      end else if (host_we_i) begin
         mem_q[host_idx_i][host_word_i] <= host_wdata_i;
      end
   end

   assign line_rdata_o = mem_q[line_idx_i];
   assign host_rdata_o = mem_q[host_idx_i][host_word_i];

endmodule

// File: rtl/hs_npu_mem_responder.sv
// hs_npu_mem_responder: line-oriented memory responder for the NPU memory port.
//   clk, rst_n     : clock, asynchronous active-low reset
//   npu (slave)    : line read/write request, read_data and mem_valid pulse
//   err_o          : sticky error (out of range, misaligned, read+write clash)
//   err_clr_i      : clears err_o (a new error in the same cycle wins)
//   host_ready_o   : backdoor access accepted this cycle
//   host_we_i/re_i : backdoor write / read strobes
//   host_addr_i    : backdoor byte address (word aligned)
//   host_wdata_i   : backdoor write word
//   host_rdata_o   : backdoor read word, valid the cycle after acceptance
// Build macro HS_NPU_MEM_RESPONDER_JITTER_EN adds 0-3 random wait cycles per
// transaction from a free-running LFSR.
module hs_npu_mem_responder
   import hs_npu_pkg::*;
#(
   parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
   parameter int DEPTH_LINES    = 256,
   parameter int READ_LATENCY   = 2,
   parameter int WRITE_LATENCY  = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   hs_npu_mem_responder_if.slave       npu,
   output logic                        err_o,
   output logic                        host_ready_o,
   input  logic                        host_we_i,
   input  logic                        host_re_i,
   input  logic [31:0]                 host_addr_i,
   input  logic [31:0]                 host_wdata_i,
   output logic [31:0]                 host_rdata_o,
   input  logic                        err_clr_i
);

   localparam int OFF_BITS = $clog2(WORDS_PER_LINE * BYTES_PER_WORD);
   localparam int IDX_BITS = $clog2(DEPTH_LINES);
   localparam int WSEL_W   = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
   localparam int MAX_LAT  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CNT_W    = $clog2(MAX_LAT + 4) + 1;

   typedef logic [WORDS_PER_LINE-1:0][31:0] line_t;

   mem_resp_state_e   state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rd_q, rd_d;
   line_t             line_q, line_d;
   line_t             read_data_q, read_data_d;
   logic              mem_valid_q, mem_valid_d;
   logic              err_q, err_d;
   logic [31:0]       host_rdata_q, host_rdata_d;

   logic [31:0]       npu_line_s;
   logic              npu_oor_s;
   logic              npu_mis_s;
   logic [31:0]       host_line_s;
   logic              host_oor_s;
   logic [WSEL_W-1:0] host_word_s;
   logic              line_we_s;
   logic              host_we_s;
   logic              new_err_s;
   line_t             arr_line_s;
   logic [31:0]       arr_word_s;
   logic [1:0]        jit_s;
   logic [CNT_W-1:0]  rd_load_s;
   logic [CNT_W-1:0]  wr_load_s;
   logic [1:0]        unused_host_lsb_s;

   // Address decode: line index is the address above the in-line offset.
   assign npu_line_s  = npu.req_address >> OFF_BITS;
   assign npu_oor_s   = (npu_line_s >= 32'(DEPTH_LINES));
   assign npu_mis_s   = ((npu.req_address & 32'(WORDS_PER_LINE * BYTES_PER_WORD - 1)) != 32'd0);
   assign host_line_s = host_addr_i >> OFF_BITS;
   assign host_oor_s  = (host_line_s >= 32'(DEPTH_LINES));
   assign host_word_s = WSEL_W'((host_addr_i >> 2) & 32'(WORDS_PER_LINE - 1));
   assign unused_host_lsb_s = host_addr_i[1:0];

`ifdef HS_NPU_MEM_RESPONDER_JITTER_EN
   logic [15:0] lfsr_q;

   // Free-running jitter source.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr16_next(lfsr_q);
      end
   end

   assign jit_s = lfsr_q[1:0];
`else
   assign jit_s = 2'b00;
`endif

   // Counter loads LATENCY-1 (+jitter) so the response lands LATENCY edges later.
   assign rd_load_s = CNT_W'(READ_LATENCY - 1) + CNT_W'(jit_s);
   assign wr_load_s = CNT_W'(WRITE_LATENCY - 1) + CNT_W'(jit_s);

   hs_npu_mem_line_array #(
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .DEPTH_LINES    (DEPTH_LINES),
      .IDX_BITS       (IDX_BITS),
      .WSEL_W         (WSEL_W)
   ) u_array (
      .clk          (clk),
      .line_we_i    (line_we_s),
      .line_idx_i   (npu_line_s[IDX_BITS-1:0]),
      .line_wdata_i (npu.write_data),
      .line_rdata_o (arr_line_s),
      .host_we_i    (host_we_s),
      .host_idx_i   (host_line_s[IDX_BITS-1:0]),
      .host_word_i  (host_word_s),
      .host_wdata_i (host_wdata_i),
      .host_rdata_o (arr_word_s)
   );

   // Next-state, array strobes, capture and error logic.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rd_d         = rd_q;
      line_d       = line_q;
      read_data_d  = read_data_q;
      mem_valid_d  = 1'b0;
      host_rdata_d = host_rdata_q;
      line_we_s    = 1'b0;
      host_we_s    = 1'b0;
      new_err_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (npu.write_req) begin
               // Write wins over a simultaneous read, which is flagged.
               line_we_s = !npu_oor_s;
               state_d   = WRITE_WAIT;
               cnt_d     = wr_load_s;
               rd_d      = 1'b0;
               new_err_s = npu_oor_s | npu_mis_s | npu.read_req;
            end else if (npu.read_req) begin
               line_d    = npu_oor_s ? '0 : arr_line_s;
               state_d   = READ_WAIT;
               cnt_d     = rd_load_s;
               rd_d      = 1'b1;
               new_err_s = npu_oor_s | npu_mis_s;
            end else begin
               // Host backdoor; read samples the word before any same-edge write.
               host_we_s = host_we_i & !host_oor_s;
               if (host_re_i) begin
                  host_rdata_d = host_oor_s ? 32'd0 : arr_word_s;
               end else begin
                  host_rdata_d = host_rdata_q;
               end
               new_err_s = (host_we_i | host_re_i) & host_oor_s;
            end
         end
         READ_WAIT, WRITE_WAIT: begin
            if (cnt_q == '0) begin
               state_d     = RESP;
               mem_valid_d = 1'b1;
               if (rd_q) begin
                  read_data_d = line_q;
               end else begin
                  read_data_d = read_data_q;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (new_err_s) begin
         err_d = 1'b1;
      end else if (err_clr_i) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         rd_q         <= 1'b0;
         line_q       <= '0;
         read_data_q  <= '0;
         mem_valid_q  <= 1'b0;
         err_q        <= 1'b0;
         host_rdata_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rd_q         <= rd_d;
         line_q       <= line_d;
         read_data_q  <= read_data_d;
         mem_valid_q  <= mem_valid_d;
         err_q        <= err_d;
         host_rdata_q <= host_rdata_d;
      end
   end

   assign npu.read_data = read_data_q;
   assign npu.mem_valid = mem_valid_q;
   assign err_o         = err_q;
   assign host_rdata_o  = host_rdata_q;
   assign host_ready_o  = (state_q == IDLE) && !npu.read_req && !npu.write_req;

endmodule

// File: tb/tb_hs_npu_mem_responder.sv
// Directed self-checking bench for hs_npu_mem_responder (default build, no jitter).
module tb_hs_npu_mem_responder;

   typedef logic [1:0][31:0] line_t;

   logic        clk;
   logic        rst_n;
   logic        err_o;
   logic        host_ready_o;
   logic        host_we_i;
   logic        host_re_i;
   logic [31:0] host_addr_i;
   logic [31:0] host_wdata_i;
   logic [31:0] host_rdata_o;
   logic        err_clr_i;

   int errors;
   int checks;

   hs_npu_mem_responder_if #(.WORDS_PER_LINE(2)) npu_if ();

   hs_npu_mem_responder #(
      .WORDS_PER_LINE (2),
      .DEPTH_LINES    (256),
      .READ_LATENCY   (2),
      .WRITE_LATENCY  (1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .npu          (npu_if),
      .err_o        (err_o),
      .host_ready_o (host_ready_o),
      .host_we_i    (host_we_i),
      .host_re_i    (host_re_i),
      .host_addr_i  (host_addr_i),
      .host_wdata_i (host_wdata_i),
      .host_rdata_o (host_rdata_o),
      .err_clr_i    (err_clr_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one NPU request, wait (bounded) for mem_valid, then one more cycle.
   task automatic npu_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input line_t wdata, output int lat, output line_t rdata,
                          output logic valid_after);
      npu_if.read_req    = rd;
      npu_if.write_req   = wr;
      npu_if.req_address = addr;
      npu_if.write_data  = wdata;
      tick();
      npu_if.read_req  = 1'b0;
      npu_if.write_req = 1'b0;
      lat   = 99;
      rdata = '0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (npu_if.mem_valid === 1'b1) begin
            lat   = i;
            rdata = npu_if.read_data;
            break;
         end
      end
      tick();
      valid_after = npu_if.mem_valid;
   endtask

   task automatic host_write(input logic [31:0] addr, input logic [31:0] data);
      host_we_i    = 1'b1;
      host_addr_i  = addr;
      host_wdata_i = data;
      tick();
      host_we_i = 1'b0;
   endtask

   task automatic host_read(input logic [31:0] addr, output logic [31:0] data);
      host_re_i   = 1'b1;
      host_addr_i = addr;
      tick();
      host_re_i = 1'b0;
      data = host_rdata_o;
   endtask

   task automatic pulse_clr();
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (npu_if.mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", npu_if.mem_valid); end
      checks++; if (npu_if.read_data !== 64'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", npu_if.read_data); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_o); end
      checks++; if (host_rdata_o !== 32'd0) begin errors++; $display("FAIL reset_hrdata got=%h exp=0", host_rdata_o); end
      checks++; if (host_ready_o !== 1'b1) begin errors++; $display("FAIL reset_hready got=%b exp=1", host_ready_o); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_read();
      int lat; line_t rd; logic va;
      host_write(32'h0, 32'h11111111);
      host_write(32'h4, 32'h22222222);
      npu_txn(1'b1, 1'b0, 32'h0, '0, lat, rd, va);
      checks++; if (lat !== 2) begin errors++; $display("FAIL read_latency got=%0d exp=2", lat); end
      checks++; if (rd !== {32'h22222222, 32'h11111111}) begin errors++; $display("FAIL read_data got=%h exp=2222222211111111", rd); end
      checks++; if (va !== 1'b0) begin errors++; $display("FAIL read_pulse_width got=%b exp=0", va); end
      checks++; if (npu_if.read_data !== {32'h22222222, 32'h11111111}) begin errors++; $display("FAIL read_data_hold got=%h exp=2222222211111111", npu_if.read_data); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL read_err got=%b exp=0", err_o); end
   endtask

   task automatic test_write();
      int lat; line_t rd; logic va; logic [31:0] w;
      npu_txn(1'b0, 1'b1, 32'h8, {32'hCAFEF00D, 32'hDEADBEEF}, lat, rd, va);
      checks++; if (lat !== 1) begin errors++; $display("FAIL write_latency got=%0d exp=1", lat); end
      checks++; if (va !== 1'b0) begin errors++; $display("FAIL write_pulse_width got=%b exp=0", va); end
      npu_txn(1'b1, 1'b0, 32'h8, '0, lat, rd, va);
      checks++; if (rd !== {32'hCAFEF00D, 32'hDEADBEEF}) begin errors++; $display("FAIL raw_data got=%h exp=cafef00ddeadbeef", rd); end
      host_read(32'hC, w);
      checks++; if (w !== 32'hCAFEF00D) begin errors++; $display("FAIL host_rd_c got=%h exp=cafef00d", w); end
      host_read(32'h8, w);
      checks++; if (w !== 32'hDEADBEEF) begin errors++; $display("FAIL host_rd_8 got=%h exp=deadbeef", w); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL write_err got=%b exp=0", err_o); end
   endtask

   task automatic test_both();
      int lat; line_t rd; logic va; logic [31:0] w;
      npu_txn(1'b1, 1'b1, 32'h10, {32'h5A5A5A5A, 32'hA5A5A5A5}, lat, rd, va);
      checks++; if (lat !== 1) begin errors++; $display("FAIL both_latency got=%0d exp=1", lat); end
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL both_err got=%b exp=1", err_o); end
      host_read(32'h10, w);
      checks++; if (w !== 32'hA5A5A5A5) begin errors++; $display("FAIL both_w0 got=%h exp=a5a5a5a5", w); end
      host_read(32'h14, w);
      checks++; if (w !== 32'h5A5A5A5A) begin errors++; $display("FAIL both_w1 got=%h exp=5a5a5a5a", w); end
      pulse_clr();
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", err_o); end
      // Clear and a new out-of-range host read in the same cycle: error wins.
      err_clr_i   = 1'b1;
      host_re_i   = 1'b1;
      host_addr_i = 32'h800;
      tick();
      err_clr_i = 1'b0;
      host_re_i = 1'b0;
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL clr_vs_err got=%b exp=1", err_o); end
      checks++; if (host_rdata_o !== 32'd0) begin errors++; $display("FAIL host_oor_rd got=%h exp=0", host_rdata_o); end
      pulse_clr();
   endtask

   task automatic test_oor();
      int lat; line_t rd; logic va;
      npu_txn(1'b1, 1'b0, 32'h800, '0, lat, rd, va);
      checks++; if (lat !== 2) begin errors++; $display("FAIL oor_latency got=%0d exp=2", lat); end
      checks++; if (rd !== 64'd0) begin errors++; $display("FAIL oor_data got=%h exp=0", rd); end
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL oor_err got=%b exp=1", err_o); end
      pulse_clr();
      npu_txn(1'b1, 1'b0, 32'h4, '0, lat, rd, va);
      checks++; if (rd !== {32'h22222222, 32'h11111111}) begin errors++; $display("FAIL mis_data got=%h exp=2222222211111111", rd); end
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL mis_err got=%b exp=1", err_o); end
      pulse_clr();
   endtask

   task automatic test_host_blocked();
      int lat; logic [31:0] w; line_t rd;
      npu_if.read_req    = 1'b1;
      npu_if.req_address = 32'h0;
      tick();
      npu_if.read_req = 1'b0;
      host_we_i    = 1'b1;
      host_addr_i  = 32'h0;
      host_wdata_i = 32'h99999999;
      #1;
      checks++; if (host_ready_o !== 1'b0) begin errors++; $display("FAIL blocked_ready got=%b exp=0", host_ready_o); end
      tick();
      host_we_i = 1'b0;
      lat = 99;
      rd  = '0;
      for (int i = 2; i <= 16; i++) begin
         tick();
         if (npu_if.mem_valid === 1'b1) begin
            lat = i;
            rd  = npu_if.read_data;
            break;
         end
      end
      tick();
      checks++; if (lat !== 2) begin errors++; $display("FAIL blocked_latency got=%0d exp=2", lat); end
      checks++; if (rd !== {32'h22222222, 32'h11111111}) begin errors++; $display("FAIL blocked_rdata got=%h exp=2222222211111111", rd); end
      host_read(32'h0, w);
      checks++; if (w !== 32'h11111111) begin errors++; $display("FAIL blocked_unchanged got=%h exp=11111111", w); end
      host_we_i    = 1'b1;
      host_addr_i  = 32'h0;
      host_wdata_i = 32'h99999999;
      #1;
      checks++; if (host_ready_o !== 1'b1) begin errors++; $display("FAIL retry_ready got=%b exp=1", host_ready_o); end
      tick();
      host_we_i = 1'b0;
      host_read(32'h0, w);
      checks++; if (w !== 32'h99999999) begin errors++; $display("FAIL retry_commit got=%h exp=99999999", w); end
      // Simultaneous write and read return the old word.
      host_we_i    = 1'b1;
      host_re_i    = 1'b1;
      host_addr_i  = 32'h4;
      host_wdata_i = 32'h77777777;
      tick();
      host_we_i = 1'b0;
      host_re_i = 1'b0;
      checks++; if (host_rdata_o !== 32'h22222222) begin errors++; $display("FAIL rw_old got=%h exp=22222222", host_rdata_o); end
      host_read(32'h4, w);
      checks++; if (w !== 32'h77777777) begin errors++; $display("FAIL rw_new got=%h exp=77777777", w); end
   endtask

   task automatic test_reset_mid();
      int lat; line_t rd; logic va;
      npu_if.read_req    = 1'b1;
      npu_if.req_address = 32'h8;
      tick();
      npu_if.read_req = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      checks++; if (host_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_idle got=%b exp=1", host_ready_o); end
      tick();
      checks++; if (npu_if.mem_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", npu_if.mem_valid); end
      rst_n = 1'b1;
      tick();
      checks++; if (npu_if.mem_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid_after got=%b exp=0", npu_if.mem_valid); end
      npu_txn(1'b1, 1'b0, 32'h8, '0, lat, rd, va);
      checks++; if (lat !== 2) begin errors++; $display("FAIL rstmid_latency got=%0d exp=2", lat); end
      checks++; if (rd !== {32'hCAFEF00D, 32'hDEADBEEF}) begin errors++; $display("FAIL rstmid_retained got=%h exp=cafef00ddeadbeef", rd); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rstmid_err got=%b exp=0", err_o); end
   endtask

   initial begin
      errors             = 0;
      checks             = 0;
      rst_n              = 1'b0;
      npu_if.read_req    = 1'b0;
      npu_if.write_req   = 1'b0;
      npu_if.req_address = 32'd0;
      npu_if.write_data  = '0;
      host_we_i          = 1'b0;
      host_re_i          = 1'b0;
      host_addr_i        = 32'd0;
      host_wdata_i       = 32'd0;
      err_clr_i          = 1'b0;
      test_reset();
      test_read();
      test_write();
      test_both();
      test_oor();
      test_host_blocked();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hs_npu_mem_responder.md
Name: hs_npu_mem_responder

Overview:
- Line-oriented memory responder on the far end of the NPU memory interface. Serves the NPU's line read requests (read-ready) and line write requests (write-valid) at a byte address.
- Returns one mem_valid pulse per transaction, backed by an internal line array.
- Word-granular host backdoor port for preloading weights/inputs and inspecting results.
- Used as the NPU's memory in simulation and FPGA bring-up.

Parameters:
- WORDS_PER_LINE, 2, 32-bit words per line; must match the NPU side.
- DEPTH_LINES, 256, lines in the array; power of two.
- READ_LATENCY, 2, cycles from request acceptance to the mem_valid_o pulse for reads; must be >=1.
- WRITE_LATENCY, 1, cycles from request acceptance to the mem_valid_o pulse for writes; must be >=1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- read_req_i  in  1  line read request (NPU mem_read_ready_o)
- write_req_i  in  1  line write request (NPU mem_write_valid_o)
- req_address_i  in  32  byte address of the line (uword)
- write_data_i  in  32 x WORDS_PER_LINE  line to write
- read_data_o  out  32 x WORDS_PER_LINE  line read
- mem_valid_o  out  1  transaction complete (NPU mem_valid_i)
- err_o  out  1  sticky error flag
- host_ready_o  out  1  backdoor access accepted this cycle
- host_we_i  in  1  backdoor write strobe
- host_re_i  in  1  backdoor read strobe
- host_addr_i  in  32  backdoor byte address; word aligned
- host_wdata_i  in  32  backdoor write word
- host_rdata_o  out  32  backdoor read word; valid the cycle after the accepted read
- err_clr_i  in  1  clears err_o

Behaviour:
- Reset values: read_data_o=0, mem_valid_o=0, err_o=0, host_rdata_o=0, state=IDLE, latency counter=0. The array is not reset.
- Address decode:
  - line index = addr >> log2(WORDS_PER_LINE*4).
  - Index >= DEPTH_LINES is out of range.
  - Nonzero low offset bits are misaligned: set err_o, offset ignored.
- FSM states: IDLE, READ_WAIT, WRITE_WAIT, RESP.
- IDLE:
  - Request sampled on every edge.
  - write_req_i=1 -> WRITE_WAIT; write_data_i is committed to the array at this edge (dropped if out of range).
  - read_req_i=1 (and no write) -> READ_WAIT; the line is captured into an internal register at this edge (zeros if out of range).
  - Both requests high -> write wins, err_o set.
  - Out-of-range request -> err_o set.
- READ_WAIT / WRITE_WAIT:
  - Counter loads LATENCY-1 at acceptance and decrements each cycle.
  - At 0 -> RESP.
  - Request inputs are ignored while waiting.
- RESP:
  - mem_valid_o=1 for exactly this one cycle.
  - For reads, read_data_o is driven from the captured line.
  - Next state is IDLE.
- Timing:
  - Request accepted at edge T -> mem_valid_o high in the cycle after edge T+LATENCY.
  - read_data_o holds its last value when mem_valid_o=0.
- Back-to-back:
  - A request still high in IDLE after RESP is a new transaction.
  - Minimum period is LATENCY+1 cycles.
  - The NPU must drop its request in the RESP cycle unless it wants a repeat.
- Read-after-write: a read accepted after a write's acceptance edge returns the new data.
- Host backdoor:
  - host_ready_o = (state==IDLE) && !read_req_i && !write_req_i. The NPU always has priority.
  - Write commits one word at the accepted edge.
  - Read returns host_rdata_o one cycle later.
  - host_we_i and host_re_i together: write performed, read returns old data.
  - Strobes while host_ready_o=0 are ignored; the host retries.
  - Out-of-range host address -> err_o set, write dropped, read returns 0.
- err_o: sticky until err_clr_i. A new error in the same cycle as err_clr_i wins (err_o stays 1).
- Reset mid-transaction: FSM returns to IDLE and no mem_valid_o is issued. An array write already committed at an earlier edge is retained.

Optional Feature:
- Macro: HS_NPU_MEM_RESPONDER_JITTER_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle.
  - At acceptance, the LFSR's low 2 bits are added to the latency, giving 0-3 extra wait cycles.
  - This stresses the NPU's handshake.
- When undefined: latency is exactly READ_LATENCY / WRITE_LATENCY, and no LFSR logic exists.

Decomposition:
- hs_npu_pkg gains:
  - mem_resp_state_e (IDLE, READ_WAIT, WRITE_WAIT, RESP)
  - BYTES_PER_WORD=4
  - typedef mem_line_t (uword array of WORDS_PER_LINE)
- One natural sub-module: hs_npu_mem_line_array. It is a single-clock line-wide array with one NPU line read/write port and one word-granular host port. Address decode, FSM and latency stay in the top.

Test Plan:
- Host preloads 2 words at 0x0/0x4 = 0x11111111/0x22222222; NPU read at 0x0 -> mem_valid_o exactly 2 cycles after acceptance, read_data_o={0x11111111,0x22222222}, err_o=0.
- NPU write {0xDEADBEEF,0xCAFEF00D} to 0x8, then read 0x8 -> WRITE ack after 1 cycle, read returns the written line; host read at 0xC -> 0xCAFEF00D.
- read_req_i and write_req_i high together at 0x10 -> write performed, err_o=1; err_clr_i pulse -> err_o=0.
- Read at 0x800 (line 256, out of range) -> mem_valid_o pulses, read_data_o=0, err_o=1; misaligned read 0x4 -> line 0 returned, err_o=1.
- Host write attempted while an NPU read is pending -> host_ready_o=0, array unchanged; retried in IDLE -> committed.
- rst_n asserted during READ_WAIT -> mem_valid_o stays 0 and state is IDLE; earlier-written line 0x8 still reads back correctly after reset.
